// File: rtl/ddr2_init_seq.sv
// DDR2 power-up initialization sequencer.
// Walks the JEDEC DDR2 init command list (PRECHARGE, EMRS2/3/1, DLL-reset MRS,
// PRECHARGE, 2x REFRESH, MRS, OCD default/exit) on a DFI-style command bus.
// Every output is registered; the bus value for a cycle is decoded from the
// state being entered, so each command occupies exactly one cycle.
module ddr2_init_seq #(
    parameter int          T_INIT_WAIT = 200,
    parameter int          T_CKE_NOP   = 80,
    parameter int          T_RP        = 4,
    parameter int          T_MRD       = 2,
    parameter int          T_RFC       = 26,
    parameter int          T_DLLK      = 200,
    parameter logic [14:0] MR_VAL      = 15'h0432,
    parameter logic [14:0] EMR1_VAL    = 15'h0044,
    parameter logic [14:0] EMR2_VAL    = 15'h0000,
    parameter logic [14:0] EMR3_VAL    = 15'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        init_done,
    output logic        cke,
    output logic [1:0]  cs_n,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [1:0]  ba,
    output logic [14:0] addr
);

    // A zero-length wait is stretched to one cycle so commands never collide.
    localparam int P_INIT = (T_INIT_WAIT < 1) ? 1 : T_INIT_WAIT;
    localparam int P_CKE  = (T_CKE_NOP   < 1) ? 1 : T_CKE_NOP;
    localparam int P_RP   = (T_RP        < 1) ? 1 : T_RP;
    localparam int P_MRD  = (T_MRD       < 1) ? 1 : T_MRD;
    localparam int P_RFC  = (T_RFC       < 1) ? 1 : T_RFC;
    localparam int P_DLLK = (T_DLLK      < 1) ? 1 : T_DLLK;

    localparam int M1   = (P_INIT > P_CKE) ? P_INIT : P_CKE;
    localparam int M2   = (M1 > P_RP) ? M1 : P_RP;
    localparam int M3   = (M2 > P_MRD) ? M2 : P_MRD;
    localparam int M4   = (M3 > P_RFC) ? M3 : P_RFC;
    localparam int MAXP = (M4 > P_DLLK) ? M4 : P_DLLK;
    localparam int CW   = $clog2(MAXP + 1);

    // Terminal counts: a state lasting N cycles leaves when its counter reads N-1.
    localparam logic [CW-1:0] L_INIT = CW'(P_INIT - 1);
    localparam logic [CW-1:0] L_CKE  = CW'(P_CKE - 1);
    localparam logic [CW-1:0] L_RP   = CW'(P_RP - 1);
    localparam logic [CW-1:0] L_MRD  = CW'(P_MRD - 1);
    localparam logic [CW-1:0] L_RFC  = CW'(P_RFC - 1);
    localparam logic [CW-1:0] L_DLLK = CW'(P_DLLK - 1);

    // A8 is the DLL-reset bit of MR; A9:A7 (OCD program) and A0 (DLL enable) of EMR1.
    localparam logic [14:0] A_MR_DLL   = MR_VAL | 15'h0100;
    localparam logic [14:0] A_MR_NODLL = MR_VAL & ~15'h0100;
    localparam logic [14:0] A_EMR1     = EMR1_VAL & ~15'h0381;
    localparam logic [14:0] A_OCDDEF   = A_EMR1 | 15'h0380;

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_MRS = 3'b000;

    typedef enum logic [3:0] {
        S_WAIT, S_CKE, S_PRE1, S_EMR2, S_EMR3, S_EMR1, S_MRDLL, S_PRE2,
        S_REF1, S_REF2, S_MR, S_OCDDEF, S_OCDEXIT, S_DLLWAIT, S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_dll;
    logic [CW-1:0]   w_lim;
    logic            w_expire;
    logic            w_enter;
    logic            w_dll_done;

    logic            w_init_done;
    logic            w_cke;
    logic [1:0]      w_cs_n;
    logic [2:0]      w_cmd;
    logic [1:0]      w_ba;
    logic [14:0]     w_addr;

    logic            r_init_done;
    logic            r_cke;
    logic [1:0]      r_cs_n;
    logic [2:0]      r_cmd;
    logic [1:0]      r_ba;
    logic [14:0]     r_addr;

    assign w_expire   = (r_cnt == w_lim);
    assign w_enter    = (w_state_nxt != r_state);
    assign w_dll_done = (r_dll == L_DLLK);

    // Next-state: each state holds for its gap, then advances in the fixed order.
    always_comb begin
        w_state_nxt = r_state;
        w_lim       = L_MRD;
        case (r_state)
            S_WAIT:    begin w_lim = L_INIT; if (w_expire) w_state_nxt = S_CKE;    end
            S_CKE:     begin w_lim = L_CKE;  if (w_expire) w_state_nxt = S_PRE1;   end
            S_PRE1:    begin w_lim = L_RP;   if (w_expire) w_state_nxt = S_EMR2;   end
            S_EMR2:    begin w_lim = L_MRD;  if (w_expire) w_state_nxt = S_EMR3;   end
            S_EMR3:    begin w_lim = L_MRD;  if (w_expire) w_state_nxt = S_EMR1;   end
            S_EMR1:    begin w_lim = L_MRD;  if (w_expire) w_state_nxt = S_MRDLL;  end
            S_MRDLL:   begin w_lim = L_MRD;  if (w_expire) w_state_nxt = S_PRE2;   end
            S_PRE2:    begin w_lim = L_RP;   if (w_expire) w_state_nxt = S_REF1;   end
            S_REF1:    begin w_lim = L_RFC;  if (w_expire) w_state_nxt = S_REF2;   end
            S_REF2:    begin w_lim = L_RFC;  if (w_expire) w_state_nxt = S_MR;     end
            S_MR:      begin w_lim = L_MRD;  if (w_expire) w_state_nxt = S_OCDDEF; end
            S_OCDDEF:  begin w_lim = L_MRD;  if (w_expire) w_state_nxt = S_OCDEXIT; end
            S_OCDEXIT: begin
                w_lim = L_MRD;
                if (w_expire) w_state_nxt = w_dll_done ? S_DONE : S_DLLWAIT;
            end
            S_DLLWAIT: begin if (w_dll_done) w_state_nxt = S_DONE; end
            S_DONE:    w_state_nxt = S_DONE;
            default:   w_state_nxt = S_WAIT;
        endcase
    end

    // Bus decode for the coming cycle: a command only on the edge a command state is entered.
    always_comb begin
        w_init_done = 1'b0;
        w_cke       = 1'b1;
        w_cs_n      = 2'b00;
        w_cmd       = CMD_NOP;
        w_ba        = 2'd0;
        w_addr      = 15'd0;
        case (w_state_nxt)
            S_WAIT: begin
                w_cke  = 1'b0;
                w_cs_n = 2'b11;
            end
            S_DONE: begin
                w_init_done = 1'b1;
                w_cs_n      = 2'b11;
            end
            S_PRE1, S_PRE2: if (w_enter) begin w_cmd = CMD_PRE; w_addr = 15'h0400; end
            S_REF1, S_REF2: if (w_enter) w_cmd = CMD_REF;
            S_EMR2:    if (w_enter) begin w_cmd = CMD_MRS; w_ba = 2'd2; w_addr = EMR2_VAL;   end
            S_EMR3:    if (w_enter) begin w_cmd = CMD_MRS; w_ba = 2'd3; w_addr = EMR3_VAL;   end
            S_EMR1:    if (w_enter) begin w_cmd = CMD_MRS; w_ba = 2'd1; w_addr = A_EMR1;     end
            S_MRDLL:   if (w_enter) begin w_cmd = CMD_MRS; w_ba = 2'd0; w_addr = A_MR_DLL;   end
            S_MR:      if (w_enter) begin w_cmd = CMD_MRS; w_ba = 2'd0; w_addr = A_MR_NODLL; end
            S_OCDDEF:  if (w_enter) begin w_cmd = CMD_MRS; w_ba = 2'd1; w_addr = A_OCDDEF;   end
            S_OCDEXIT: if (w_enter) begin w_cmd = CMD_MRS; w_ba = 2'd1; w_addr = A_EMR1;     end
            default: ;
        endcase
    end

    // State register and per-state gap counter (cleared on every transition, saturating).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_enter)
                r_cnt <= '0;
            else if (r_cnt != {CW{1'b1}})
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // DLL lock counter: restarts on the DLL-reset MRS and stops at its terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dll <= '0;
        else if (w_enter && (w_state_nxt == S_MRDLL))
            r_dll <= '0;
        else if (!w_dll_done)
            r_dll <= r_dll + 1'b1;
    end

    // Output registers; reset forces the deselect/cke-low bus immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_done <= 1'b0;
            r_cke       <= 1'b0;
            r_cs_n      <= 2'b11;
            r_cmd       <= CMD_NOP;
            r_ba        <= 2'd0;
            r_addr      <= 15'd0;
        end else begin
            r_init_done <= w_init_done;
            r_cke       <= w_cke;
            r_cs_n      <= w_cs_n;
            r_cmd       <= w_cmd;
            r_ba        <= w_ba;
            r_addr      <= w_addr;
        end
    end

    assign init_done = r_init_done;
    assign cke       = r_cke;
    assign cs_n      = r_cs_n;
    assign ras_n     = r_cmd[2];
    assign cas_n     = r_cmd[1];
    assign we_n      = r_cmd[0];
    assign ba        = r_ba;
    assign addr      = r_addr;

endmodule
